// File: rtl/ps_pkg.sv
// Types shared by the ps memory slave and its bench.
package ps_pkg;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_RESP  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/ps_if.sv
// ps protocol bundle: independent write channel and handshaked read channel.
interface ps_if #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic                  wresp;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  arvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  waddr, wdata, wvalid, raddr, arvalid, rready,
    output wready, wresp, rdata, rvalid
  );

  modport master (
    output waddr, wdata, wvalid, raddr, arvalid, rready,
    input  wready, wresp, rdata, rvalid
  );
endinterface

// File: rtl/ps_ram.sv
// Single write port, registered read port; a same-edge read returns the old word.
module ps_ram #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 32,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ps_mem_slave.sv
// ps protocol memory responder: clears itself after reset, then serves writes and reads
// independently.
module ps_mem_slave
  import ps_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  ps_if.slave  bus,
  output logic init_done
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  // Extra bit keeps the compare meaningful when DEPTH is a power of two.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_EXT;
  endfunction

  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  wresp_q;
  rd_state_e             rd_state_q, rd_state_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic                  raddr_ok_q, raddr_ok_d;

  logic                  wr_accept;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign wr_accept = bus.wvalid && init_done_q;
  // Clearing owns the write port until init_done; out-of-range writes are dropped.
  assign ram_we    = !init_done_q || (wr_accept && in_range(bus.waddr));
  assign ram_waddr = init_done_q ? bus.waddr : clr_cnt_q;
  assign ram_wdata = init_done_q ? bus.wdata : '0;
  assign ram_re    = (rd_state_q == R_FETCH) && raddr_ok_q;

  always_comb begin
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    if (!init_done_q) begin
      if (clr_cnt_q == LAST_ADDR) init_done_d = 1'b1;
      else                        clr_cnt_d   = clr_cnt_q + 1'b1;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    raddr_d    = raddr_q;
    raddr_ok_d = raddr_ok_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (init_done_q && bus.arvalid) begin
          raddr_d    = bus.raddr;
          raddr_ok_d = in_range(bus.raddr);
          rd_state_d = R_FETCH;
        end
      end
      R_FETCH: rd_state_d = R_RESP;
      R_RESP:  if (bus.rready) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      wresp_q     <= 1'b0;
      rd_state_q  <= R_IDLE;
      raddr_q     <= '0;
      raddr_ok_q  <= 1'b0;
    end else begin
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      wresp_q     <= wr_accept;
      rd_state_q  <= rd_state_d;
      raddr_q     <= raddr_d;
      raddr_ok_q  <= raddr_ok_d;
    end
  end

  ps_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (raddr_q),
    .rdata (ram_rdata)
  );

  assign init_done  = init_done_q;
  assign bus.wready = init_done_q;
  assign bus.wresp  = wresp_q;
  assign bus.rvalid = (rd_state_q == R_RESP);
  // Out-of-range reads answer zero; outside R_RESP the bus sees zero too.
  assign bus.rdata  = (rd_state_q == R_RESP && raddr_ok_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_ps_mem_slave.sv
// Drives a DEPTH=32 and a DEPTH=20 slave in lockstep and scoreboards their read data.
module tb_ps_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  waddr = '0;
  logic [4:0]  raddr = '0;
  logic [31:0] wdata = '0;
  logic        wvalid = 1'b0;
  logic        arvalid = 1'b0;
  logic        rready = 1'b1;
  logic        init_done32, init_done20;

  always #5 clk = ~clk;

  ps_if #(.DEPTH(32), .DATA_WIDTH(32)) b32 ();
  ps_if #(.DEPTH(20), .DATA_WIDTH(32)) b20 ();

  assign b32.waddr   = waddr;
  assign b32.wdata   = wdata;
  assign b32.wvalid  = wvalid;
  assign b32.raddr   = raddr;
  assign b32.arvalid = arvalid;
  assign b32.rready  = rready;
  assign b20.waddr   = waddr;
  assign b20.wdata   = wdata;
  assign b20.wvalid  = wvalid;
  assign b20.raddr   = raddr;
  assign b20.arvalid = arvalid;
  assign b20.rready  = rready;

  ps_mem_slave #(.DEPTH(32), .DATA_WIDTH(32)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (b32),
    .init_done (init_done32)
  );

  ps_mem_slave #(.DEPTH(20), .DATA_WIDTH(32)) dut20 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (b20),
    .init_done (init_done20)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m32 [32];
  logic [31:0] m20 [20];
  logic [31:0] q32 [$];
  logic [31:0] q20 [$];
  logic [5:0]  cnt32, cnt20;
  logic        wresp_exp32, wresp_exp20;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt32       <= '0;
      cnt20       <= '0;
      wresp_exp32 <= 1'b0;
      wresp_exp20 <= 1'b0;
    end else begin
      if (cnt32 != 6'd32) cnt32 <= cnt32 + 6'd1;
      if (cnt20 != 6'd20) cnt20 <= cnt20 + 6'd1;
      wresp_exp32 <= wvalid && (cnt32 == 6'd32);
      wresp_exp20 <= wvalid && (cnt20 == 6'd20);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_wready32", 32'(b32.wready), 32'd0);
      check("rst_rvalid32", 32'(b32.rvalid), 32'd0);
      check("rst_rdata32", b32.rdata, 32'd0);
      check("rst_wresp32", 32'(b32.wresp), 32'd0);
      check("rst_init32", 32'(init_done32), 32'd0);
      check("rst_rvalid20", 32'(b20.rvalid), 32'd0);
      check("rst_init20", 32'(init_done20), 32'd0);
    end else begin
      check("wready32", 32'(b32.wready), 32'(cnt32 == 6'd32));
      check("init32", 32'(init_done32), 32'(cnt32 == 6'd32));
      check("wresp32", 32'(b32.wresp), 32'(wresp_exp32));
      check("wready20", 32'(b20.wready), 32'(cnt20 == 6'd20));
      check("init20", 32'(init_done20), 32'(cnt20 == 6'd20));
      check("wresp20", 32'(b20.wresp), 32'(wresp_exp20));
      if (b32.rvalid && rready) begin
        if (q32.size() == 0) check("rd32_unexpected", 32'd1, 32'd0);
        else check("rdata32", b32.rdata, q32.pop_front());
      end else if (b32.rvalid && q32.size() > 0) begin
        check("rdata32_hold", b32.rdata, q32[0]);
      end
      if (b20.rvalid && rready) begin
        if (q20.size() == 0) check("rd20_unexpected", 32'd1, 32'd0);
        else check("rdata20", b20.rdata, q20.pop_front());
      end else if (b20.rvalid && q20.size() > 0) begin
        check("rdata20_hold", b20.rdata, q20[0]);
      end
    end
  end

  // One cycle of stimulus; the model applies a same-cycle write before sampling a read.
  task automatic cycle_drive(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                             input bit re, input logic [4:0] ra);
    @(posedge clk);
    #1;
    wvalid  = we;
    waddr   = wa;
    wdata   = wd;
    arvalid = re;
    raddr   = ra;
    if (we) begin
      m32[wa] = wd;
      if (wa < 5'd20) m20[wa] = wd;
    end
    if (re) begin
      q32.push_back(m32[ra]);
      q20.push_back(ra < 5'd20 ? m20[ra] : 32'd0);
    end
  endtask

  task automatic idle();
    cycle_drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic rd_finish(input int lat0, input int hold);
    int lat = lat0;
    rready = (hold == 0);
    while (!b32.rvalid && lat < 8) begin
      idle();
      lat++;
    end
    check("rd_latency", 32'(lat), 32'd2);
    for (int i = 0; i < hold; i++) begin
      check("rvalid_held", 32'(b32.rvalid), 32'd1);
      idle();
    end
    rready = 1'b1;
    check("rvalid_hs", 32'(b32.rvalid), 32'd1);
    idle();
    check("rvalid_drop32", 32'(b32.rvalid), 32'd0);
    check("rvalid_drop20", 32'(b20.rvalid), 32'd0);
  endtask

  task automatic rd(input logic [4:0] a, input int hold);
    cycle_drive(1'b0, 5'd0, 32'd0, 1'b1, a);
    rd_finish(0, hold);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) m32[i] = '0;
    for (int i = 0; i < 20; i++) m20[i] = '0;
    q32.delete();
    q20.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (31) idle();
    check("init32_cycle31", 32'(init_done32), 32'd0);
    idle();
    check("init32_cycle32", 32'(init_done32), 32'd1);

    for (int a = 0; a < 32; a++) rd(5'(a), 0);

    cycle_drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    idle();
    check("wresp_pulse", 32'(b32.wresp), 32'd1);
    idle();
    check("wresp_single", 32'(b32.wresp), 32'd0);
    rd(5'd5, 0);
    rd(5'd5, 4);

    // 25 exists in the 32-word slave but is out of range for the 20-word one.
    cycle_drive(1'b1, 5'd25, 32'h1234, 1'b0, 5'd0);
    idle();
    check("wresp_oob20", 32'(b20.wresp), 32'd1);
    rd(5'd25, 0);
    rd(5'd5, 0);
    rd(5'd19, 0);

    for (int i = 0; i < 4; i++) cycle_drive(1'b1, 5'(10 + i), 32'(i * 32'h111 + 1), 1'b0, 5'd0);
    idle();
    idle();
    for (int i = 0; i < 4; i++) rd(5'(10 + i), 0);

    cycle_drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd3);
    rd_finish(0, 0);
    cycle_drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    cycle_drive(1'b1, 5'd3, 32'hB, 1'b0, 5'd0);
    rd_finish(1, 0);
    rd(5'd3, 0);

    // Write while a response is being held
    cycle_drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
    rready = 1'b0;
    idle();
    cycle_drive(1'b1, 5'd12, 32'h5555, 1'b0, 5'd0);
    rd_finish(2, 2);
    rd(5'd12, 0);

    // Reset while a response is pending
    cycle_drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    rready = 1'b0;
    idle();
    idle();
    check("resp_before_rst", 32'(b32.rvalid), 32'd1);
    #2 rst_n = 1'b0;
    clear_model();
    #1;
    check("rvalid_async_rst32", 32'(b32.rvalid), 32'd0);
    check("rvalid_async_rst20", 32'(b20.rvalid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rready = 1'b1;
    repeat (20) idle();
    check("reinit20", 32'(init_done20), 32'd1);
    check("reinit32_early", 32'(init_done32), 32'd0);
    repeat (12) idle();
    check("reinit32", 32'(init_done32), 32'd1);
    rd(5'd5, 0);
    rd(5'd3, 0);
    rd(5'd25, 0);

    repeat (3) idle();
    check("q32_drained", 32'(q32.size()), 32'd0);
    check("q20_drained", 32'(q20.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
